// File: rtl/pmem_line_bridge.sv
// Wishbone line (LINE_W) to pmem beat (BEAT_W) bridge: writes are serialised, read beats are reassembled.
// Optional build macro PMEM_BEAT_SKIP_EN: write beats with an all-zero byte-select slice issue no pmem request.
module pmem_line_bridge #(
    parameter int ADDR_W = 12,
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wb_cyc,
    input  logic                                  wb_stb,
    input  logic                                  wb_we,
    input  logic [LINE_W/8-1:0]                   wb_sel,
    input  logic [ADDR_W-1:0]                     wb_adr,
    input  logic [LINE_W-1:0]                     wb_dat_m,
    output logic [LINE_W-1:0]                     wb_dat_s,
    output logic                                  wb_ack,
    output logic                                  wb_rty,
    output logic                                  pmem_read,
    output logic                                  pmem_write,
    output logic [ADDR_W+$clog2(LINE_W/8)-1:0]    pmem_address,
    output logic [BEAT_W-1:0]                     pmem_wdata,
    output logic [BEAT_W/8-1:0]                   pmem_wmask,
    input  logic [BEAT_W-1:0]                     pmem_rdata,
    input  logic                                  pmem_resp,
    output logic [1:0]                            dbg_state_o
);

    // LINE_W must be an exact multiple of BEAT_W, with at least two beats per line.
    localparam int BEATS   = LINE_W / BEAT_W;
    localparam int BIDX_W  = $clog2(BEATS);
    localparam int BSEL_W  = BEAT_W / 8;
    localparam int BOFF_W  = $clog2(BSEL_W);
    localparam int SEL_W   = LINE_W / 8;

    // Handshake: a request is wb_cyc&wb_stb seen in IDLE; it completes with a single-cycle wb_ack,
    // and wb_rty mirrors the request while a line is in flight. A pmem beat is held until pmem_resp.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WR_BEAT = 2'd1,
        S_RD_BEAT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BIDX_W-1:0]   beat_q,  beat_d;
    logic [ADDR_W-1:0]   adr_q,   adr_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [LINE_W-1:0]   wline_q, wline_d;
    logic [LINE_W-1:0]   rline_q, rline_d;

    logic [BSEL_W-1:0]   cur_sel;
    logic                beat_last;
    logic                beat_skip;
    logic                rest_masked;
    logic [ADDR_W+BIDX_W+BOFF_W-1:0] beat_addr;

    assign cur_sel   = sel_q[beat_q*BSEL_W +: BSEL_W];
    assign beat_last = (beat_q == BIDX_W'(BEATS-1));
    assign beat_addr = {adr_q, beat_q, {BOFF_W{1'b0}}};

`ifdef PMEM_BEAT_SKIP_EN
    // rest_masked covers the current beat and every later one, so a trailing run of empty beats ends at once.
    assign beat_skip   = (cur_sel == '0);
    assign rest_masked = ((sel_q >> (beat_q*BSEL_W)) == '0);
`else
    assign beat_skip   = 1'b0;
    assign rest_masked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            adr_q   <= '0;
            sel_q   <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        wline_d      = wline_q;
        rline_d      = rline_q;
        wb_ack       = 1'b0;
        wb_rty       = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        pmem_wmask   = '0;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d  = wb_adr;
                    sel_d  = wb_sel;
                    beat_d = '0;
                    if (wb_we) begin
                        wline_d = wb_dat_m;
                        state_d = S_WR_BEAT;
                    end else begin
                        state_d = S_RD_BEAT;
                    end
                end
            end

            S_WR_BEAT: begin
                wb_rty       = wb_cyc & wb_stb;
                pmem_address = beat_addr;
                if (beat_skip) begin
                    if (rest_masked) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BIDX_W'(1);
                    end
                end else begin
                    pmem_write = 1'b1;
                    pmem_wdata = wline_q[beat_q*BEAT_W +: BEAT_W];
                    pmem_wmask = cur_sel;
                    if (pmem_resp) begin
                        if (beat_last) begin
                            state_d = S_DONE;
                        end else begin
                            beat_d = beat_q + BIDX_W'(1);
                        end
                    end
                end
            end

            S_RD_BEAT: begin
                wb_rty       = wb_cyc & wb_stb;
                pmem_read    = 1'b1;
                pmem_address = beat_addr;
                if (pmem_resp) begin
                    rline_d[beat_q*BEAT_W +: BEAT_W] = pmem_rdata;
                    if (beat_last) begin
                        state_d = S_DONE;
                    end else begin
                        beat_d = beat_q + BIDX_W'(1);
                    end
                end
            end

            S_DONE: begin
                wb_ack  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The read line is only ever overwritten by read beat captures, so it holds across writes.
    assign wb_dat_s    = rline_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/pmem_line_bridge.md
Name: pmem_line_bridge

Overview:
- Sits directly downstream of the L2 eviction/fill path and consumes its wishbone master port (128-bit line read/write transactions).
- Serialises each line into BEATS narrow transfers on the physical-memory beat interface and reassembles read beats into a line.
- Returns a one-cycle ACK on completion and asserts RTY while busy, matching the ACK/RTY semantics the upstream stage expects.

Parameters:
- ADDR_W, 12, wishbone line-address width; byte address width is ADDR_W+log2(LINE_W/8) = 16.
- LINE_W, 128, line width in bits.
- BEAT_W, 32, pmem beat width in bits; BEATS = LINE_W/BEAT_W = 4; LINE_W must be an exact multiple of BEAT_W.

Ports:
- clk  in  1  rising-edge clock, same clock as wishbone CLK.
- rst_n  in  1  asynchronous active-low reset.
- wb_cyc  in  1  wishbone cycle.
- wb_stb  in  1  wishbone strobe.
- wb_we  in  1  1 = line write, 0 = line read.
- wb_sel  in  LINE_W/8  byte selects.
- wb_adr  in  ADDR_W  line address.
- wb_dat_m  in  LINE_W  write line.
- wb_dat_s  out  LINE_W  read line.
- wb_ack  out  1  transaction complete.
- wb_rty  out  1  busy, retry.
- pmem_read  out  1  beat read request.
- pmem_write  out  1  beat write request.
- pmem_address  out  ADDR_W+4  byte address of the current beat.
- pmem_wdata  out  BEAT_W  write beat data.
- pmem_wmask  out  BEAT_W/8  write byte mask.
- pmem_rdata  in  BEAT_W  read beat data.
- pmem_resp  in  1  current beat done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, beat=0, line buffer=0. All outputs 0: wb_ack, wb_rty, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask, wb_dat_s. Reset mid-transaction abandons the transaction; no ACK is issued.
- States: IDLE, WR_BEAT, RD_BEAT, DONE.
- IDLE:
  - wb_cyc&wb_stb accepts the request and latches wb_adr, wb_we, wb_sel and wb_dat_m (if writing); beat:=0.
  - Next state is WR_BEAT or RD_BEAT. wb_rty=0 in IDLE.
- WR_BEAT:
  - pmem_write=1.
  - pmem_address={adr, beat, 2'b00}.
  - pmem_wdata=line[beat*BEAT_W +: BEAT_W].
  - pmem_wmask=sel[beat*4 +: 4].
  - On pmem_resp: if beat==BEATS-1 go to DONE, else beat+1. The request stays asserted; the address/data update the cycle after resp.
- RD_BEAT:
  - pmem_read=1, pmem_wmask=0, same address rule.
  - On pmem_resp: capture pmem_rdata into line[beat] in the same edge, then advance as in WR_BEAT.
  - All bytes are read regardless of wb_sel.
- DONE:
  - wb_ack=1 for exactly one cycle, pmem_read/pmem_write=0, then IDLE.
  - A request still present in the cycle after DONE is treated as new; upstream drops STB on ACK.
- wb_rty=wb_cyc&wb_stb in WR_BEAT/RD_BEAT, 0 in IDLE/DONE.
- wb_dat_s is the line buffer. It is valid during the ACK of a read and holds until the next read beat capture.
- Latency with zero-wait pmem (resp in the request cycle): accept edge at cycle N, beats in N+1..N+4, ACK at N+5.
- Inputs changing during a transaction are ignored (all fields latched). pmem_resp in IDLE/DONE is ignored.
- pmem_read and pmem_write are never both 1.

Optional Feature:
- Macro: PMEM_BEAT_SKIP_EN.
- Defined: in WR_BEAT, a beat whose 4-bit sel slice is 0000 is skipped without a pmem request. The beat index advances in one cycle. If all remaining beats are masked, the FSM goes straight to DONE; an all-zero wb_sel write reaches ACK at N+2.
- Undefined: every write issues all BEATS beats; masked beats go out with pmem_wmask=0000.

Test Plan:
- Reset: assert rst_n=0 mid-WR_BEAT (beat=2), release -> all outputs 0, state IDLE, no wb_ack; next request completes normally.
- Full write: adr=12'h0A3, dat_m=128'h0123..CDEF, sel=FFFF, zero-wait pmem -> pmem_address 16'h0A30, 0A34, 0A38, 0A3C with matching 32-bit slices (low word first), mask 1111, wb_ack at N+5 for one cycle.
- Read with 2-cycle pmem latency per beat: pmem returns 11111111, 22222222, 33333333, 44444444 -> wb_dat_s=128'h44444444_33333333_22222222_11111111 at ACK, which arrives at N+9.
- Busy retry: second STB held during the first transaction -> wb_rty=1 every busy cycle, 0 at ACK; the request is accepted in the IDLE cycle after DONE.
- Partial write sel=16'h00F0: without macro -> 4 beats, masks 0000, 1111, 0000, 0000; with PMEM_BEAT_SKIP_EN -> single beat at adr|4, ACK at N+4.
- Input perturbation: change wb_adr/wb_dat_m after accept -> pmem beats use the latched values only.
